// File: rtl/ps2_rx_fifo_if.sv
// CPU-side bundle of the PS/2 receiver: key FIFO head, pop/clear controls,
// sticky error flags and the receive FSM state for observation.
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // key_valid is the valid and key_pop the ready: a byte leaves the FIFO in
    // any cycle where both are high; key_pop while key_valid is low is ignored.
    logic          key_pop;
    logic          err_clr;
    logic          key_valid;
    logic [7:0]    key_data;
    logic          key_perr;
    logic [CW-1:0] fifo_count;
    logic          frame_err;
    logic          overflow;
    logic [1:0]    dbg_state;

    modport master (
        output key_pop, err_clr,
        input  key_valid, key_data, key_perr, fifo_count, frame_err, overflow, dbg_state
    );

    modport slave (
        input  key_pop, err_clr,
        output key_valid, key_data, key_perr, fifo_count, frame_err, overflow, dbg_state
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: glitch-filtered clock sampling, odd-parity
// check, frame timeout and a first-word-fall-through scan-code FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_CYCLES  = 750,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic clk,
    input  logic reset,
    inout  wire  ps2_clk,
    inout  wire  ps2_data,
    ps2_rx_fifo_if.slave bus
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          strobe;
    logic          rx_bit;

    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    logic          push_req, push_perr, frame_evt;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop, push_ok, ovf_evt;
    logic          frame_err_q, frame_err_d, overflow_q, overflow_d;
    logic [8:0]    head;

    // The PS/2 lines are open-collector and this block only listens.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) begin
                filt_clk_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    assign strobe  = filt_clk_q && !filt_clk_d;
    assign rx_bit  = dat_sync_q[1];
    assign tmo_hit = (state_q != S_IDLE) && !strobe && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        if (state_q == S_IDLE || strobe || tmo_hit) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
        if (tmo_hit) begin
            state_d = S_IDLE;
        end else if (strobe) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_bit) begin
                        state_d   = S_DATA;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {rx_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = rx_bit;
                    state_d = S_STOP;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        push_req  = 1'b0;
        frame_evt = tmo_hit;
        push_perr = ~(^shift_q ^ par_q);
        if (state_q == S_STOP && strobe) begin
            if (rx_bit) push_req  = 1'b1;
            else        frame_evt = 1'b1;
        end
    end

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    always_comb begin
        pop      = bus.key_pop && (count_q != '0);
        push_ok  = push_req && ((count_q < CW'(FIFO_DEPTH)) || pop);
        ovf_evt  = push_req && !push_ok;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = {push_perr, shift_q};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        frame_err_d = frame_evt || (frame_err_q && !bus.err_clr);
        overflow_d  = ovf_evt || (overflow_q && !bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign bus.key_valid  = (count_q != '0);
    assign bus.key_data   = bus.key_valid ? head[7:0] : 8'h00;
    assign bus.key_perr   = bus.key_valid ? head[8] : 1'b0;
    assign bus.fifo_count = count_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: hand-built PS/2 frames, glitches, timeouts,
// FIFO overflow and mid-frame reset, checked with immediate assertions.
module tb_ps2_rx_fifo;
    localparam int FILT  = 4;
    localparam int TMO   = 200;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk_drv = 1'b1;
    logic ps2_data_drv = 1'b1;
    wire  ps2_clk_w;
    wire  ps2_data_w;
    int   n_assert = 0;
    int   n_fail = 0;
    logic [7:0] exp_heads [4];

    assign ps2_clk_w  = ps2_clk_drv;
    assign ps2_data_w = ps2_data_drv;

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_rx_fifo #(
        .FILTER_CYCLES (FILT),
        .TIMEOUT_CYCLES(TMO),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk_w),
        .ps2_data(ps2_data_w),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    task automatic send_bit(input logic b);
        ps2_data_drv = b;
        tick(HALF / 2);
        ps2_clk_drv = 1'b0;
        tick(HALF);
        ps2_clk_drv = 1'b1;
        tick(HALF / 2);
    endtask

    task automatic send_head(input logic [7:0] b, input logic p);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        send_head(b, p);
        send_bit(s);
        ps2_data_drv = 1'b1;
    endtask

    task automatic pop_one();
        bus.key_pop = 1'b1;
        tick(1);
        bus.key_pop = 1'b0;
    endtask

    task automatic clr_err();
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.key_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.key_data),  32'h00);
        chk({tag, "_perr"},  32'(bus.key_perr),  32'd0);
        chk({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
        chk({tag, "_ferr"},  32'(bus.frame_err), 32'd0);
        chk({tag, "_ovf"},   32'(bus.overflow),  32'd0);
        chk({tag, "_state"}, 32'(bus.dbg_state), 32'd0);
    endtask

    initial begin
        bus.key_pop = 1'b0;
        bus.err_clr = 1'b0;
        exp_heads = '{8'h02, 8'h03, 8'h04, 8'h06};

        // reset state
        tick(3);
        reset = 1'b0;
        tick(1);
        chk_all_zero("rst");

        // 0x1C, good parity; key_valid rises 6 edges after the stop-bit fall
        send_head(8'h1C, 1'b0);
        ps2_data_drv = 1'b1;
        tick(HALF / 2);
        ps2_clk_drv = 1'b0;
        tick(5);
        chk("f1_valid_early", 32'(bus.key_valid), 32'd0);
        tick(1);
        chk("f1_valid", 32'(bus.key_valid), 32'd1);
        chk("f1_data",  32'(bus.key_data),  32'h1C);
        chk("f1_perr",  32'(bus.key_perr),  32'd0);
        chk("f1_count", 32'(bus.fifo_count), 32'd1);
        tick(HALF - 6);
        ps2_clk_drv = 1'b1;
        tick(HALF / 2);
        pop_one();
        chk("f1_pop_valid", 32'(bus.key_valid), 32'd0);
        chk("f1_pop_data",  32'(bus.key_data),  32'h00);
        chk("f1_pop_count", 32'(bus.fifo_count), 32'd0);

        // parity error tagging, then bad stop bit
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("pe_valid", 32'(bus.key_valid), 32'd1);
        chk("pe_data",  32'(bus.key_data),  32'h1C);
        chk("pe_perr",  32'(bus.key_perr),  32'd1);
        pop_one();
        send_frame(8'hF0, 1'b1, 1'b0);
        chk("stop_valid", 32'(bus.key_valid), 32'd0);
        chk("stop_ferr",  32'(bus.frame_err), 32'd1);
        clr_err();
        chk("stop_clr",   32'(bus.frame_err), 32'd0);

        // fill, overflow, push with simultaneous pop
        for (int i = 1; i <= 4; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1);
        chk("fill_count", 32'(bus.fifo_count), 32'd4);
        chk("fill_head",  32'(bus.key_data),  32'h01);
        chk("fill_ovf",   32'(bus.overflow),  32'd0);
        send_frame(8'h05, odd_par(8'h05), 1'b1);
        chk("ovf_flag",  32'(bus.overflow),  32'd1);
        chk("ovf_count", 32'(bus.fifo_count), 32'd4);
        send_head(8'h06, odd_par(8'h06));
        ps2_data_drv = 1'b1;
        tick(HALF / 2);
        ps2_clk_drv = 1'b0;
        tick(5);
        bus.key_pop = 1'b1;
        tick(1);
        bus.key_pop = 1'b0;
        chk("pp_count", 32'(bus.fifo_count), 32'd4);
        chk("pp_head",  32'(bus.key_data),  32'h02);
        tick(HALF - 6);
        ps2_clk_drv = 1'b1;
        tick(HALF / 2);
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", 32'(bus.key_data), 32'(exp_heads[i]));
            pop_one();
        end
        chk("drain_valid", 32'(bus.key_valid), 32'd0);
        chk("drain_count", 32'(bus.fifo_count), 32'd0);
        chk("drain_ovf",   32'(bus.overflow),  32'd1);
        clr_err();
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        // 3-cycle glitch is filtered out
        ps2_clk_drv = 1'b0;
        tick(3);
        ps2_clk_drv = 1'b1;
        tick(HALF);
        chk("glitch_state", 32'(bus.dbg_state), 32'd0);
        chk("glitch_valid", 32'(bus.key_valid), 32'd0);

        // partial frame, then timeout
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(150);
        chk("tmo_pre_state", 32'(bus.dbg_state), 32'd1);
        chk("tmo_pre_ferr",  32'(bus.frame_err), 32'd0);
        tick(50);
        chk("tmo_state", 32'(bus.dbg_state), 32'd0);
        chk("tmo_ferr",  32'(bus.frame_err), 32'd1);
        clr_err();
        send_frame(8'hE0, 1'b0, 1'b1);
        chk("e0_data",  32'(bus.key_data),  32'hE0);
        chk("e0_perr",  32'(bus.key_perr),  32'd0);
        chk("e0_count", 32'(bus.fifo_count), 32'd1);
        chk("e0_ferr",  32'(bus.frame_err), 32'd0);
        pop_one();

        // reset mid-frame with two entries held
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        chk("pre_rst_count", 32'(bus.fifo_count), 32'd2);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'(i % 2));
        chk("pre_rst_state", 32'(bus.dbg_state), 32'd1);
        ps2_data_drv = 1'b1;
        reset = 1'b1;
        tick(1);
        chk_all_zero("mid_rst");
        reset = 1'b0;
        tick(2);
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("5a_data",  32'(bus.key_data),  32'h5A);
        chk("5a_perr",  32'(bus.key_perr),  32'd0);
        chk("5a_count", 32'(bus.fifo_count), 32'd1);
        pop_one();

        // set beats clear in the same cycle
        send_head(8'h33, odd_par(8'h33));
        ps2_data_drv = 1'b0;
        tick(HALF / 2);
        ps2_clk_drv = 1'b0;
        tick(5);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        chk("setclr_ferr",  32'(bus.frame_err), 32'd1);
        chk("setclr_valid", 32'(bus.key_valid), 32'd0);
        ps2_data_drv = 1'b1;
        tick(HALF - 6);
        ps2_clk_drv = 1'b1;
        tick(HALF / 2);
        clr_err();
        chk("final_ferr", 32'(bus.frame_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised, fully synchronous PS/2 device-to-host receiver with odd-parity checking, frame timeout and a first-word-fall-through receive FIFO. It sits between the external PS/2 connector and the CPU-side keyboard peripheral register. It replaces single-byte, edge-clocked capture with filtered single-clock sampling, per-byte error tagging and buffering of up to FIFO_DEPTH scan codes.

## Interface
- FILTER_CYCLES, 750: consecutive `clk` cycles the synchronised PS/2 clock must hold a new level before the filtered clock follows it (15 µs at 50 MHz).
- TIMEOUT_CYCLES, 100000: `clk` cycles allowed between sample strobes inside a frame (2 ms at 50 MHz).
- FIFO_DEPTH, 8: receive FIFO entries; power of two, ≥2.
- clk  in  1  system clock; everything below is in this domain.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  inout  1  PS/2 clock; never driven, always high-Z.
- ps2_data  inout  1  PS/2 data; never driven, always high-Z.
- key_pop  in  1  pop the FIFO head; ignored when `key_valid`=0.
- err_clr  in  1  clears `frame_err` and `overflow`.
- key_valid  out  1  FIFO non-empty.
- key_data  out  8  head byte; 0 when empty.
- key_perr  out  1  head byte failed parity; 0 when empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held, 0..FIFO_DEPTH.
- frame_err  out  1  sticky: bad stop bit or timeout.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- Synchronise each PS/2 line through two flops, both reset to 1.
- Filter: the filtered clock starts at 1. A counter increments while the synchronised clock differs from the filtered clock and clears when they match. When the count reaches FILTER_CYCLES-1 with the lines still differing, the filtered clock takes the new level and the counter clears.
- Sample strobe: the cycle in which the filtered clock goes 1→0. Capture synchronised data in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only on strobes, except timeout and reset.
  - IDLE: strobe with data=0 → DATA and clear the shift register and bit counter. Strobe with data=1 is ignored.
  - DATA: shift in LSB first (bit 0 first). After the 8th bit → PARITY.
  - PARITY: store the bit → STOP. Parity is OK when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - STOP: data=1 → push {perr, byte} and go to IDLE. data=0 → no push, set `frame_err`, go to IDLE.
- Timeout: in any state other than IDLE, count cycles since the last strobe. At TIMEOUT_CYCLES, discard the partial frame, set `frame_err` and go to IDLE. The counter is held at 0 in IDLE.
- FIFO: first-word fall-through, so `key_data` and `key_perr` show the head combinationally from registered storage.
  - Pop occurs when `key_pop` && `key_valid`.
  - A push is accepted when `fifo_count` < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the push is dropped and `overflow` is set.
  - Push and pop in the same cycle: count is unchanged and order is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: set has priority over `err_clr` in the same cycle.
- Reset, including mid-frame: state IDLE, partial frame discarded, FIFO empty, all outputs 0, filtered clock and sync flops at 1, all counters 0.

## Timing
- Raw `ps2_clk` fall to strobe: 2 + FILTER_CYCLES cycles, if the line is stable.
- Push is registered at the end of the stop-bit strobe cycle. `key_valid`, `key_data` and `fifo_count` update on the next cycle, one cycle after the strobe.
- Pop takes effect at the clock edge. The next head is visible in the following cycle.
- `frame_err` and `overflow` assert in the cycle after the causing event.
- Throughput: one byte per 11 strobes. The FIFO sustains a pop every cycle.

## Test plan
Bench parameters: FILTER_CYCLES=4, TIMEOUT_CYCLES=200, FIFO_DEPTH=4. PS/2 half-period is 20 cycles.
- Frame 0x1C, parity bit 0, stop 1 → `key_valid`=1 one cycle after the stop strobe, `key_data`=0x1C, `key_perr`=0, `fifo_count`=1. Pulse `key_pop` → `key_valid`=0 and `key_data`=0 the next cycle.
- Frame 0x1C, parity bit 1 → entry 0x1C with `key_perr`=1. Frame 0xF0, stop bit 0 → no push, `frame_err`=1. Pulse `err_clr` → `frame_err`=0.
- Push 0x01..0x04 → `fifo_count`=4. Push 0x05 → dropped, `overflow`=1. Push 0x06 arrives with a pop in the same cycle → accepted, count stays 4. Pops then yield 0x02, 0x03, 0x04, 0x06.
- 3-cycle low glitch on `ps2_clk` while in IDLE → no strobe, FSM stays in IDLE. A start bit plus 3 data bits followed by silence → after 200 cycles `frame_err`=1, FSM in IDLE. A following 0xE0 frame is received correctly.
- Assert `reset` after the 5th data bit of a frame, with 2 entries in the FIFO → next cycle the FIFO is empty and all outputs are 0. The next full frame 0x5A decodes correctly.
- `err_clr` in the same cycle as a new stop-bit error → `frame_err` stays 1.
